check_reg_responder: RTL and testbench
======================================

Name: check_reg_responder

Overview:
- Responder end of the checker register-query interface used by the MIPS verification environment.
- Maintains a shadow 32-entry register file by snooping the DUT's register-file writeback port.
- The instruction checker issues rs/rt/rd index requests. This block answers them:
  - rs/rt operand values one cycle after the request.
  - rd result value when the matching DUT writeback appears, or a timeout error if it does not.
- Sits beside the MIPS core in the bench, between the core's writeback bus and the checker.

Parameters:
- DATA_W, 32, register data width.
- PEND_DEPTH, 4, depth of pending-rd FIFO (power of two, >=2).
- TIMEOUT, 16, max cycles the FIFO head may wait for its writeback.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  checker request strobe, one cycle per instruction.
- req_rs  input  5  source register index.
- req_rt  input  5  second source register index.
- req_rd  input  5  destination index to track (0 = no destination).
- rs_value  output  DATA_W  shadow value of req_rs.
- rt_value  output  DATA_W  shadow value of req_rt.
- rsp_valid  output  1  rs_value/rt_value valid pulse.
- wb_en  input  1  DUT register-file write enable (snooped).
- wb_addr  input  5  DUT write index.
- wb_data  input  DATA_W  DUT write data.
- rd_value  output  DATA_W  captured result for FIFO-head rd.
- rd_valid  output  1  rd_value valid pulse.
- timeout_err  output  1  pulse: head rd not written within TIMEOUT cycles.
- overflow  output  1  sticky: request arrived with pending FIFO full.
- pend_count  output  $clog2(PEND_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst_n low):
  - All 32 shadow registers = 0.
  - rs_value = rt_value = rd_value = 0.
  - rsp_valid, rd_valid, timeout_err, overflow = 0.
  - pend_count = 0; FSM = IDLE; timeout counter = 0.
  - Reset mid-operation discards all pending entries with no pulses.
- Shadow file:
  - On wb_en with wb_addr != 0, entry[wb_addr] <= wb_data.
  - Entry 0 is always 0; writes to index 0 are ignored.
- Operand response:
  - req_valid in cycle N gives rsp_valid = 1 in N+1, with rs_value/rt_value from the file.
  - Write-first bypass: if wb_en in cycle N targets req_rs (or req_rt) and the index != 0, the returned value is wb_data.
  - rs_value/rt_value hold their value between responses.
- Pending FIFO:
  - req_valid pushes req_rd.
  - If full and no pop occurs in the same cycle: push dropped, overflow set (cleared only by reset); rsp_valid is still produced.
  - Simultaneous push and pop when full is legal; occupancy is unchanged and overflow is not set.
  - Pointers wrap modulo PEND_DEPTH.
- Head FSM:
  - IDLE: FIFO empty; go to WAIT when the FIFO becomes non-empty, counter = 0.
  - WAIT, head rd == 0: resolve in the first WAIT cycle. Next cycle rd_value = 0, rd_valid = 1; pop.
  - WAIT, wb_en with wb_addr == head rd: next cycle rd_value = wb_data, rd_valid = 1; pop.
  - WAIT, counter reaches TIMEOUT-1 without a match: next cycle timeout_err = 1, rd_value = 0, rd_valid = 0; pop.
  - Otherwise in WAIT: counter increments.
  - After any pop: go to WAIT with counter = 0 if entries remain, else IDLE.
  - Only the head compares against writebacks. A writeback to a non-head rd updates the shadow file only.
  - Match and timeout in the same cycle: match wins.
  - Pop plus push in the same cycle to an empty-after-pop FIFO: the new entry becomes head next cycle.
- Latency:
  - Operands: 1 cycle.
  - rd: 1 cycle after the matching writeback.
  - All outputs are registered.

Test Plan:
- Reset then req_valid rs=0, rt=0, rd=0 -> next cycle rsp_valid = 1, rs_value = rt_value = 0; following cycle rd_valid = 1, rd_value = 0; overflow = 0.
- wb_en addr=5 data=0x0000_0007, then req rs=5, rt=6 -> rs_value = 7, rt_value = 0. Same-cycle wb addr=6 data=0x12 with req rt=6 -> rt_value = 0x12 (bypass).
- req rd=3, then after 4 idle cycles wb addr=3 data=0xDEAD_BEEF -> one cycle later rd_valid = 1, rd_value = 0xDEADBEEF, pend_count back to 0.
- req rd=9 with no writeback -> timeout_err pulses exactly TIMEOUT cycles after entering WAIT (16), rd_valid never asserts, FIFO empties.
- 5 back-to-back requests rd=1..5 with no writebacks (depth 4) -> overflow = 1, pend_count = 4. Then wb 1,2,3,4 on consecutive cycles -> four rd_valid pulses in order with the matching data.
- Pull rst_n low while pend_count = 3 -> outputs 0 immediately (async). After release, a writeback to a previously pending rd produces no rd_valid.

Source files
------------

// File: rtl/check_reg_responder.sv
// Checker-side register query responder: shadows the core's register file from its
// writeback port, answers rs/rt operand queries and tracks pending rd results in a FIFO.
module check_reg_responder #(
    parameter int DATA_W     = 32,
    parameter int PEND_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    input  logic [4:0]                    req_rs,
    input  logic [4:0]                    req_rt,
    input  logic [4:0]                    req_rd,
    output logic [DATA_W-1:0]             rs_value,
    output logic [DATA_W-1:0]             rt_value,
    output logic                          rsp_valid,
    input  logic                          wb_en,
    input  logic [4:0]                    wb_addr,
    input  logic [DATA_W-1:0]             wb_data,
    output logic [DATA_W-1:0]             rd_value,
    output logic                          rd_valid,
    output logic                          timeout_err,
    output logic                          overflow,
    output logic [$clog2(PEND_DEPTH):0]   pend_count
);
    // state | meaning
    // IDLE  | pending FIFO empty, nothing to resolve
    // WAIT  | FIFO head waiting for its writeback, cnt_q counts cycles spent waiting

    localparam int PW = $clog2(PEND_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(PEND_DEPTH);
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t              state_q;
    logic [TW-1:0]       cnt_q;
    logic [DATA_W-1:0]   regs_q [32];
    logic [4:0]          fifo_q [PEND_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic [DATA_W-1:0]   rs_value_q, rt_value_q, rd_value_q;
    logic                rsp_valid_q, rd_valid_q, timeout_err_q, overflow_q;

    logic [4:0]          head_rd;
    logic                in_wait, hit_zero, hit_wb, expire, pop, push, drop, full;

    always_comb begin
        head_rd  = fifo_q[rd_ptr_q];
        in_wait  = (state_q == ST_WAIT);
        hit_zero = in_wait && (head_rd == 5'd0);
        hit_wb   = in_wait && (head_rd != 5'd0) && wb_en && (wb_addr == head_rd);
        // a matching writeback beats a timeout landing in the same cycle
        expire   = in_wait && !hit_zero && !hit_wb && (cnt_q == CNT_LAST);
        pop      = hit_zero || hit_wb || expire;
        full     = (count_q == FULL_CNT);
        push     = req_valid && (!full || pop);
        drop     = req_valid && full && !pop;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wb_en && (wb_addr == 5'(i))) begin
                    regs_q[i] <= wb_data;
                end
            end
        end
    end

    // operand lookup sees a same-cycle writeback (write-first)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_value_q  <= '0;
            rt_value_q  <= '0;
            rsp_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rsp_valid_q <= req_valid;
            if (req_valid) begin
                rs_value_q <= (wb_en && (wb_addr == req_rs) && (req_rs != 5'd0)) ? wb_data : regs_q[req_rs];
                rt_value_q <= (wb_en && (wb_addr == req_rt) && (req_rt != 5'd0)) ? wb_data : regs_q[req_rt];
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < PEND_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= req_rd;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rd_value_q    <= '0;
            rd_valid_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            rd_valid_q    <= hit_zero || hit_wb;
            timeout_err_q <= expire;
            if (hit_wb) begin
                rd_value_q <= wb_data;
            end else if (hit_zero || expire) begin
                rd_value_q <= '0;
            end
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (push) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (pop) begin
                        cnt_q   <= '0;
                        state_q <= (count_d != '0) ? ST_WAIT : ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rs_value    = rs_value_q;
    assign rt_value    = rt_value_q;
    assign rsp_valid   = rsp_valid_q;
    assign rd_value    = rd_value_q;
    assign rd_valid    = rd_valid_q;
    assign timeout_err = timeout_err_q;
    assign overflow    = overflow_q;
    assign pend_count  = count_q;

endmodule

// File: tb/tb_check_reg_responder.sv
// Bench for check_reg_responder: hand vectors, multi-cycle corner sequences and
// random traffic against a queue-based reference model.
module tb_check_reg_responder;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] rs_value, rt_value, rd_value;
    logic        rsp_valid, rd_valid, timeout_err, overflow;
    logic [2:0]  pend_count;

    int checks   = 0;
    int failures = 0;

    check_reg_responder #(.DATA_W(32), .PEND_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .rs_value(rs_value), .rt_value(rt_value), .rsp_valid(rsp_valid),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_value(rd_value), .rd_valid(rd_valid), .timeout_err(timeout_err),
        .overflow(overflow), .pend_count(pend_count)
    );

    always #5 clk = ~clk;

    // reference model: shadow array plus a queue of pending rd indices
    logic [31:0] m_reg [32];
    int          m_q [$];
    int          m_age;
    logic        e_rsp, e_rdv, e_tmo, e_ovf;
    logic [31:0] e_rs, e_rt, e_rdval;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_q.delete();
        m_age = 0;
        e_rsp = 0; e_rdv = 0; e_tmo = 0; e_ovf = 0;
        e_rs = '0; e_rt = '0; e_rdval = '0;
    endtask

    task automatic model_step();
        bit popped;
        if (!rst_n) begin
            model_clear();
            return;
        end
        e_rsp = req_valid;
        if (req_valid) begin
            e_rs = (wb_en && wb_addr == req_rs && req_rs != 0) ? wb_data : m_reg[req_rs];
            e_rt = (wb_en && wb_addr == req_rt && req_rt != 0) ? wb_data : m_reg[req_rt];
        end
        e_rdv  = 0;
        e_tmo  = 0;
        popped = 0;
        if (m_q.size() > 0) begin
            if (m_q[0] == 0) begin
                e_rdv = 1; e_rdval = '0; popped = 1;
            end else if (wb_en && int'(wb_addr) == m_q[0]) begin
                e_rdv = 1; e_rdval = wb_data; popped = 1;
            end else if (m_age == TMO - 1) begin
                e_tmo = 1; e_rdval = '0; popped = 1;
            end else begin
                m_age++;
            end
            if (popped) begin
                void'(m_q.pop_front());
                m_age = 0;
            end
        end
        if (req_valid) begin
            if (m_q.size() < DEPTH) m_q.push_back(int'(req_rd));
            else e_ovf = 1;
        end
        if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
    endtask

    task automatic model_check();
        chk("m_rsp_valid", 64'(rsp_valid), 64'(e_rsp));
        chk("m_rs_value", 64'(rs_value), 64'(e_rs));
        chk("m_rt_value", 64'(rt_value), 64'(e_rt));
        chk("m_rd_valid", 64'(rd_valid), 64'(e_rdv));
        chk("m_rd_value", 64'(rd_value), 64'(e_rdval));
        chk("m_timeout_err", 64'(timeout_err), 64'(e_tmo));
        chk("m_overflow", 64'(overflow), 64'(e_ovf));
        chk("m_pend_count", 64'(pend_count), 64'(m_q.size()));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_rs = 0; req_rt = 0; req_rd = 0;
        wb_en = 0; wb_addr = 0; wb_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic req(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        req_valid = 1; req_rs = rs; req_rt = rt; req_rd = rd;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
    endtask

    typedef struct {
        logic        rv;
        logic [4:0]  rs, rt, rd;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        e_rsp;
        logic [31:0] e_rs, e_rt;
        logic        e_rdv;
        logic [31:0] e_rdval;
        int          e_pend;
    } vec_t;

    vec_t vt [9];

    initial begin
        int first;
        bit saw;
        rst_n = 0;
        idle_inputs();
        model_clear();
        #2;
        chk("reset_pend_count", 64'(pend_count), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        do_reset();

        //        rv rs  rt  rd  we  wa  wd            rsp rs         rt         rdv rdval        pend
        vt[0] = '{1, 0,  0,  0,  0,  0,  32'h0,        1,  32'h0,     32'h0,     0,  32'h0,        1};
        vt[1] = '{0, 0,  0,  0,  1,  5,  32'h7,        0,  32'h0,     32'h0,     1,  32'h0,        0};
        vt[2] = '{1, 5,  6,  0,  0,  0,  32'h0,        1,  32'h7,     32'h0,     0,  32'h0,        1};
        vt[3] = '{1, 5,  6,  0,  1,  6,  32'h12,       1,  32'h7,     32'h12,    1,  32'h0,        1};
        vt[4] = '{0, 0,  0,  0,  0,  0,  32'h0,        0,  32'h7,     32'h12,    1,  32'h0,        0};
        vt[5] = '{1, 6,  0,  0,  1,  0,  32'hFFFF,     1,  32'h12,    32'h0,     0,  32'h0,        1};
        vt[6] = '{0, 0,  0,  0,  0,  0,  32'h0,        0,  32'h12,    32'h0,     1,  32'h0,        0};
        vt[7] = '{1, 7,  7,  7,  1,  7,  32'hAB,       1,  32'hAB,    32'hAB,    0,  32'h0,        1};
        vt[8] = '{0, 0,  0,  0,  1,  7,  32'hCD,       0,  32'hAB,    32'hAB,    1,  32'hCD,       0};

        for (int i = 0; i < 9; i++) begin
            req_valid = vt[i].rv; req_rs = vt[i].rs; req_rt = vt[i].rt; req_rd = vt[i].rd;
            wb_en = vt[i].we; wb_addr = vt[i].wa; wb_data = vt[i].wd;
            tick();
            chk($sformatf("vec%0d_rsp_valid", i), 64'(rsp_valid), 64'(vt[i].e_rsp));
            chk($sformatf("vec%0d_rs_value", i), 64'(rs_value), 64'(vt[i].e_rs));
            chk($sformatf("vec%0d_rt_value", i), 64'(rt_value), 64'(vt[i].e_rt));
            chk($sformatf("vec%0d_rd_valid", i), 64'(rd_valid), 64'(vt[i].e_rdv));
            chk($sformatf("vec%0d_rd_value", i), 64'(rd_value), 64'(vt[i].e_rdval));
            chk($sformatf("vec%0d_pend_count", i), 64'(pend_count), 64'(vt[i].e_pend));
            chk($sformatf("vec%0d_overflow", i), 64'(overflow), 64'd0);
        end
        idle_inputs();

        // rd result arrives after several idle cycles
        req(0, 0, 3); tick(); idle_inputs();
        for (int i = 0; i < 4; i++) tick();
        chk("rd3_pending", 64'(pend_count), 64'd1);
        wb(3, 32'hDEAD_BEEF); tick(); idle_inputs();
        chk("rd3_valid", 64'(rd_valid), 64'd1);
        chk("rd3_value", 64'(rd_value), 64'hDEAD_BEEF);
        chk("rd3_pend_zero", 64'(pend_count), 64'd0);

        // timeout: pulse exactly TMO cycles after the head enters WAIT
        req(0, 0, 9); tick(); idle_inputs();
        first = -1; saw = 0;
        for (int k = 1; k <= TMO + 8; k++) begin
            tick();
            if (timeout_err && first < 0) first = k;
            if (rd_valid) saw = 1;
        end
        chk("tmo_cycle", 64'(first), 64'(TMO));
        chk("tmo_no_rd_valid", 64'(saw), 64'd0);
        chk("tmo_pend_zero", 64'(pend_count), 64'd0);

        // overflow then in-order drain on consecutive writebacks
        do_reset();
        chk("ovf_clear_after_reset", 64'(overflow), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            req(0, 0, 5'(i)); tick();
        end
        idle_inputs();
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_pend_full", 64'(pend_count), 64'(DEPTH));
        for (int i = 1; i <= 4; i++) begin
            wb(5'(i), 32'h1000 + 32'(i)); tick();
            chk($sformatf("drain%0d_rd_valid", i), 64'(rd_valid), 64'd1);
            chk($sformatf("drain%0d_rd_value", i), 64'(rd_value), 64'h1000 + 64'(i));
        end
        idle_inputs(); tick();
        chk("drain_pend_zero", 64'(pend_count), 64'd0);

        // full with simultaneous pop: push accepted, overflow untouched
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            req(0, 0, 5'(i)); tick();
        end
        req(0, 0, 5'd20); wb(1, 32'h55); tick(); idle_inputs();
        chk("fullpop_overflow", 64'(overflow), 64'd0);
        chk("fullpop_pend", 64'(pend_count), 64'(DEPTH));
        chk("fullpop_rd_value", 64'(rd_value), 64'h55);

        // async reset mid-operation discards pending entries
        do_reset();
        for (int i = 10; i <= 12; i++) begin
            req(0, 0, 5'(i)); tick();
        end
        idle_inputs();
        chk("rst_pend_before", 64'(pend_count), 64'd3);
        #2 rst_n = 0;
        #1;
        chk("async_rst_pend", 64'(pend_count), 64'd0);
        chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("async_rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("async_rst_rd_value", 64'(rd_value), 64'd0);
        tick();
        rst_n = 1;
        wb(10, 32'h77); tick(); idle_inputs(); tick();
        chk("post_rst_no_rd_valid", 64'(rd_valid), 64'd0);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom_range(0, 2) == 0);
            req_rs    = 5'($urandom_range(0, 7));
            req_rt    = 5'($urandom_range(0, 7));
            req_rd    = 5'($urandom_range(0, 7));
            wb_en     = 1'($urandom_range(0, 1));
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 3 * TMO; i++) tick();
        chk("final_pend_zero", 64'(pend_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
